n64adv_ctrl_event: RTL
======================

// Module: n64adv_ctrl_event
// PURPOSE
// - Consumes the 32-bit controller words delivered by the controller sniffer and turns them into events.
// - Produces button press pulses, prioritised OSD menu navigation events with auto-repeat,
//   a held-combo IGR reset request, and a controller-lost flag.
// - Sits directly downstream of the sniffer, in the CLK_4M domain; outputs feed OSD/menu logic and reset driver.
// PARAMETERS
// - IGR_COMBO   16'h0000  button word [15:0] that arms the IGR reset; exact match required
// - HOLD_POLLS  8'd30     consecutive matching polls before IGR_RST_REQ fires (1..255)
// - RPT_DELAY   6'd20     polls from first direction event to first repeat (1..63)
// - RPT_RATE    6'd4      polls between subsequent repeats (1..63)
// - STICK_TH    8'd40     stick deflection magnitude treated as a direction (1..127)
// - TO_CYCLES   19'd400000 CLK_4M cycles without CTRL_VALID before CTRL_LOST (~100 ms)
// PORTS
// - CLK_4M          in   1   block clock
// - SRST            in   1   synchronous reset, active-high
// - CTRL_DATA       in   32  [7:0] A,B,Z,St,Du,Dd,Dl,Dr; [15:8] JR,0,L,R,Cu,Cd,Cl,Cr; [23:16] X; [31:24] Y (signed)
// - CTRL_VALID      in   1   one-cycle strobe; CTRL_DATA is valid in that cycle
// - IGR_EN          in   1   enables the IGR combo detector (level)
// - KEY_PRESS       out  16  one-cycle pulse per bit of a newly pressed button (0->1 between polls)
// - MENU_EVT        out  3   0 none, 1 up, 2 down, 3 left, 4 right, 5 enter(A), 6 back(B)
// - MENU_EVT_VALID  out  1   one-cycle pulse qualifying MENU_EVT
// - IGR_RST_REQ     out  1   one-cycle pulse when combo is held for HOLD_POLLS polls
// - CTRL_LOST       out  1   level; high while no poll seen for TO_CYCLES cycles
// BEHAVIOUR
// - Clocking/reset: single clock, CLK_4M. SRST is synchronous and active-high.
//   SRST has priority over every other input.
// - Reset values: every output is 0, except MENU_EVT = 3'd0.
//   Internal button history, direction history, counters and FSM are cleared; the FSM enters IDLE.
// - Latency: all outputs are registered. Pulses appear exactly 1 cycle after the CTRL_VALID cycle.
//   Outside poll processing every pulse output is 0.
// - KEY_PRESS = CTRL_DATA[15:0] & ~btn_prev; btn_prev is then updated to CTRL_DATA[15:0].
// - Direction, with priority up > down > left > right:
//   - up = Du | (Y >= +STICK_TH); down = Dd | (Y <= -STICK_TH)
//   - left = Dl | (X <= -STICK_TH); right = Dr | (X >= +STICK_TH)
//   - compares are signed 8-bit; -128 is valid and counts as full deflection.
// - Navigation FSM, evaluated once per CTRL_VALID:
//   - IDLE: dir != none -> emit dir, cnt = RPT_DELAY, go to DELAY.
//     Else, if KEY_PRESS A emit 5; else if KEY_PRESS B emit 6.
//   - DELAY/REPEAT: dir == none -> IDLE, no event.
//     dir != dir_prev -> emit new dir, cnt = RPT_DELAY, go to DELAY.
//     Otherwise cnt--. When cnt reaches 0, emit dir, cnt = RPT_RATE, state = REPEAT.
//   - A/B events are emitted only when no direction is active (at most one event per poll).
// - IGR detector:
//   - On CTRL_VALID with IGR_EN and CTRL_DATA[15:0] == IGR_COMBO: hold_cnt++ (saturating at 255).
//   - IGR_RST_REQ pulses once, on the poll where hold_cnt becomes HOLD_POLLS.
//   - Any non-matching poll, or IGR_EN low, clears hold_cnt and re-arms the detector.
// - Timeout:
//   - to_cnt clears on CTRL_VALID and otherwise increments, saturating.
//   - When to_cnt reaches TO_CYCLES-1, CTRL_LOST goes to 1. At the same time btn_prev, dir_prev and
//     hold_cnt clear and the FSM enters IDLE; no events are emitted.
//   - The next CTRL_VALID clears CTRL_LOST in the same update in which it is processed as a fresh poll.
// - Simultaneous events: CTRL_VALID in the timeout-expiry cycle -> the poll wins and CTRL_LOST stays 0.
// - Reset mid-hold or mid-repeat: counters are lost and no pulse is emitted in the reset cycle or the one after.
// - Back-to-back CTRL_VALID (consecutive cycles) must each be processed; no stalling.
// TESTING
// - Reset: SRST=1 for 2 cycles, then 0 -> all outputs 0 and MENU_EVT=0.
//   First poll 32'h0000_0001 -> KEY_PRESS=16'h0001, MENU_EVT=5 pulse.
// - Press A repeatedly: polls 0x0001, 0x0001, 0x0000, 0x0001 -> KEY_PRESS pulses on polls 1 and 4 only.
// - Auto-repeat, defaults: 40 polls with Du=1 (0x0010) -> MENU_EVT=1 on polls 1, 21, 25, 29, 33, 37;
//   switching to Y=8'hC0 (down) -> MENU_EVT=2 on that poll.
// - Stick threshold: X=8'd39 -> no event; X=8'd40 -> MENU_EVT=4; X=8'h80 -> MENU_EVT=3.
// - IGR: IGR_COMBO=16'h3010, IGR_EN=1, 30 matching polls -> exactly one IGR_RST_REQ, 1 cycle after poll 30.
//   Repeat with a miss at poll 15 -> no pulse until 30 further matches.
// - Timeout: no CTRL_VALID for 400000 cycles -> CTRL_LOST=1; next poll with Du held -> CTRL_LOST=0 and MENU_EVT=1.

Source files
------------

// File: rtl/n64adv_ctrl_event.sv
// N64 controller event decoder: button edges, OSD navigation with
// auto-repeat, IGR reset combo detector and controller-lost timeout.
module n64adv_ctrl_event #(
  parameter logic [15:0] IGR_COMBO  = 16'h0000,
  parameter logic [7:0]  HOLD_POLLS = 8'd30,
  parameter logic [5:0]  RPT_DELAY  = 6'd20,
  parameter logic [5:0]  RPT_RATE   = 6'd4,
  parameter logic [7:0]  STICK_TH   = 8'd40,
  parameter logic [18:0] TO_CYCLES  = 19'd400000
) (
  input  logic        CLK_4M,
  input  logic        SRST,
  input  logic [31:0] CTRL_DATA,
  input  logic        CTRL_VALID,
  input  logic        IGR_EN,
  output logic [15:0] KEY_PRESS,
  output logic [2:0]  MENU_EVT,
  output logic        MENU_EVT_VALID,
  output logic        IGR_RST_REQ,
  output logic        CTRL_LOST
);

  localparam logic [2:0] EV_NONE  = 3'd0;
  localparam logic [2:0] EV_UP    = 3'd1;
  localparam logic [2:0] EV_DOWN  = 3'd2;
  localparam logic [2:0] EV_LEFT  = 3'd3;
  localparam logic [2:0] EV_RIGHT = 3'd4;
  localparam logic [2:0] EV_ENTER = 3'd5;
  localparam logic [2:0] EV_BACK  = 3'd6;

  localparam logic [18:0] TO_LAST = TO_CYCLES - 19'd1;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } nav_state_t;

  nav_state_t state, state_nx;

  logic [15:0] btn_prev;
  logic [2:0]  dir_prev;
  logic [5:0]  cnt, cnt_nx, cnt_dec;
  logic [7:0]  hold_cnt, hold_nx;
  logic [18:0] to_cnt;

  logic [15:0] kp;
  logic [2:0]  dir;
  logic [2:0]  evt_nx;
  logic        evt_vld_nx;
  logic        igr_nx;
  logic        expire;

  logic signed [8:0] sx, sy, th_p, th_n;
  logic up, dn, lt, rt;

  // Stick axes sign-extended to 9 bits so -128 and -STICK_TH compare cleanly
  assign sx   = {CTRL_DATA[23], CTRL_DATA[23:16]};
  assign sy   = {CTRL_DATA[31], CTRL_DATA[31:24]};
  assign th_p = {1'b0, STICK_TH};
  assign th_n = -th_p;

  assign up = CTRL_DATA[4] | (sy >= th_p);
  assign dn = CTRL_DATA[5] | (sy <= th_n);
  assign lt = CTRL_DATA[6] | (sx <= th_n);
  assign rt = CTRL_DATA[7] | (sx >= th_p);

  always_comb begin
    dir = EV_NONE;
    priority case (1'b1)
      up:      dir = EV_UP;
      dn:      dir = EV_DOWN;
      lt:      dir = EV_LEFT;
      rt:      dir = EV_RIGHT;
      default: dir = EV_NONE;
    endcase
  end

  assign kp      = CTRL_DATA[15:0] & ~btn_prev;
  assign cnt_dec = cnt - 6'd1;
  assign expire  = !CTRL_VALID && !CTRL_LOST && (to_cnt == TO_LAST);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    evt_nx     = EV_NONE;
    evt_vld_nx = 1'b0;
    if (expire) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (CTRL_VALID) begin
      unique case (state)
        IDLE: begin
          if (dir != EV_NONE) begin
            evt_nx     = dir;
            evt_vld_nx = 1'b1;
            cnt_nx     = RPT_DELAY;
            state_nx   = DELAY;
          end else if (kp[0]) begin
            evt_nx     = EV_ENTER;
            evt_vld_nx = 1'b1;
          end else if (kp[1]) begin
            evt_nx     = EV_BACK;
            evt_vld_nx = 1'b1;
          end
        end
        DELAY, REPEAT: begin
          if (dir == EV_NONE) begin
            state_nx = IDLE;
          end else if (dir != dir_prev) begin
            evt_nx     = dir;
            evt_vld_nx = 1'b1;
            cnt_nx     = RPT_DELAY;
            state_nx   = DELAY;
          end else if (cnt_dec == 6'd0) begin
            evt_nx     = dir;
            evt_vld_nx = 1'b1;
            cnt_nx     = RPT_RATE;
            state_nx   = REPEAT;
          end else begin
            cnt_nx = cnt_dec;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Pulse only on the transition into HOLD_POLLS so a held combo fires once
  always_comb begin
    hold_nx = hold_cnt;
    igr_nx  = 1'b0;
    if (expire || !IGR_EN) begin
      hold_nx = '0;
    end else if (CTRL_VALID) begin
      if (CTRL_DATA[15:0] == IGR_COMBO) begin
        if (hold_cnt != 8'hFF)
          hold_nx = hold_cnt + 8'd1;
        if (hold_cnt == HOLD_POLLS - 8'd1)
          igr_nx = 1'b1;
      end else begin
        hold_nx = '0;
      end
    end
  end

  always_ff @(posedge CLK_4M) begin
    if (SRST) begin
      state          <= IDLE;
      cnt            <= '0;
      hold_cnt       <= '0;
      btn_prev       <= '0;
      dir_prev       <= EV_NONE;
      to_cnt         <= '0;
      KEY_PRESS      <= '0;
      MENU_EVT       <= EV_NONE;
      MENU_EVT_VALID <= 1'b0;
      IGR_RST_REQ    <= 1'b0;
      CTRL_LOST      <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      hold_cnt       <= hold_nx;
      MENU_EVT       <= evt_nx;
      MENU_EVT_VALID <= evt_vld_nx;
      IGR_RST_REQ    <= igr_nx;
      KEY_PRESS      <= CTRL_VALID ? kp : 16'h0000;
      if (CTRL_VALID) begin
        btn_prev  <= CTRL_DATA[15:0];
        dir_prev  <= dir;
        to_cnt    <= '0;
        CTRL_LOST <= 1'b0;
      end else begin
        if (to_cnt != TO_LAST)
          to_cnt <= to_cnt + 19'd1;
        if (expire) begin
          CTRL_LOST <= 1'b1;
          btn_prev  <= '0;
          dir_prev  <= EV_NONE;
        end
      end
    end
  end

endmodule
